// File: rtl/fp32_pkg.sv
// Shared binary32 format constants and the unpacked view used by the adder.
package fp32_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic [31:0] fp_inf(input logic s);
        return {s, 8'hFF, 23'd0};
    endfunction
endpackage

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; returns 24 when the input is all zero.
module fp_lzc24 (
    input  logic [23:0] data_i,
    output logic [4:0]  count_o
);
    always_comb begin
        count_o = 5'd24;
        // Scanning upward lets the highest set bit make the final assignment.
        for (int i = 0; i < 24; i++) begin
            if (data_i[i]) begin
                count_o = 5'(23 - i);
            end
        end
    end
endmodule

// File: rtl/floating_point_adder.sv
// binary32 adder (flush-to-zero, round-to-nearest-even) with one output register.
module floating_point_adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out
);
    localparam logic signed [9:0] EXP_INF = 10'(EXP_MAX);

    fp32_t a, b, l, s;
    logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic  a_ge, eff_sub;

    assign a = A;
    assign b = B;

    assign a_nan  = (a.exp == 8'hFF) && (a.frac != '0);
    assign b_nan  = (b.exp == 8'hFF) && (b.frac != '0);
    assign a_inf  = (a.exp == 8'hFF) && (a.frac == '0);
    assign b_inf  = (b.exp == 8'hFF) && (b.frac == '0);
    assign a_zero = (a.exp == 8'h00);
    assign b_zero = (b.exp == 8'h00);

    assign a_ge    = {a.exp, a.frac} >= {b.exp, b.frac};
    assign l       = a_ge ? a : b;
    assign s       = a_ge ? b : a;
    assign eff_sub = a.sign ^ b.sign;

    // Alignment: 24-bit mantissa plus guard, round and sticky.
    logic [7:0]  d_exp;
    logic [23:0] m_l, m_s;
    logic [49:0] s_shift;
    logic [26:0] l_al, s_al;

    assign d_exp   = l.exp - s.exp;
    assign m_l     = {1'b1, l.frac};
    assign m_s     = {1'b1, s.frac};
    assign s_shift = {m_s, 26'd0} >> d_exp;
    assign s_al    = (d_exp >= 8'd26) ? 27'd1 : {s_shift[49:24], |s_shift[23:0]};
    assign l_al    = {m_l, 3'b000};

    logic [27:0] sum;
    logic [26:0] diff, diff_norm;
    logic [4:0]  lz;

    assign sum  = {1'b0, l_al} + {1'b0, s_al};
    assign diff = l_al - s_al;

    fp_lzc24 u_lzc (
        .data_i  (diff[26:3]),
        .count_o (lz)
    );

    // A count of 24 only occurs when the leading one sits in the guard bit.
    assign diff_norm = diff << lz;

    logic [23:0]       mant;
    logic              g_bit, r_bit, s_bit;
    logic signed [9:0] exp_n;

    always_comb begin
        mant  = sum[26:3];
        g_bit = sum[2];
        r_bit = sum[1];
        s_bit = sum[0];
        exp_n = $signed({2'b00, l.exp});
        if (eff_sub) begin
            mant  = diff_norm[26:3];
            g_bit = diff_norm[2];
            r_bit = diff_norm[1];
            s_bit = diff_norm[0];
            exp_n = $signed({2'b00, l.exp}) - $signed({5'd0, lz});
        end else if (sum[27]) begin
            mant  = sum[27:4];
            g_bit = sum[3];
            r_bit = sum[2];
            s_bit = sum[1] | sum[0];
            exp_n = $signed({2'b00, l.exp}) + 10'sd1;
        end
    end

    logic              round_inc;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [22:0]       frac_r;

    assign round_inc = g_bit & (r_bit | s_bit | mant[0]);
    assign mant_r    = {1'b0, mant} + {24'd0, round_inc};
    assign exp_r     = exp_n + $signed({9'd0, mant_r[24]});
    assign frac_r    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    logic [31:0] out_d, out_q;

    always_comb begin
        out_d = {l.sign, exp_r[7:0], frac_r};
        if (a_nan || b_nan) begin
            out_d = QNAN;
        end else if (a_inf && b_inf) begin
            out_d = eff_sub ? QNAN : fp_inf(a.sign);
        end else if (a_inf) begin
            out_d = fp_inf(a.sign);
        end else if (b_inf) begin
            out_d = fp_inf(b.sign);
        end else if (a_zero && b_zero) begin
            out_d = {a.sign & b.sign, 31'd0};
        end else if (a_zero) begin
            out_d = B;
        end else if (b_zero) begin
            out_d = A;
        end else if (eff_sub && (diff == 27'd0)) begin
            out_d = 32'd0;
        end else if (exp_n <= 10'sd0) begin
            out_d = {l.sign, 31'd0};
        end else if (exp_r >= EXP_INF) begin
            out_d = fp_inf(l.sign);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 32'd0;
        end else begin
            out_q <= out_d;
        end
    end

    assign Out = out_q;
endmodule

// File: tb/tb_floating_point_adder.sv
// Bench for floating_point_adder: directed vector table, reset sequence, random model check.
module tb_floating_point_adder;
    logic        clk;
    logic        rst;
    logic [31:0] A, B, Out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    floating_point_adder dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Out (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: exact double arithmetic, then RNE to binary32 with FTZ.
    function automatic real fp_to_real(input logic [31:0] x);
        logic [10:0] de;
        de = 11'(int'(x[30:23]) + 896);
        return $bitstoreal({x[31], de, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] bits;
        logic [52:0] m53;
        logic [23:0] keep;
        logic [28:0] rem;
        logic [24:0] m;
        logic        inc;
        int          fe;
        bits = $realtobits(r);
        if (bits[62:52] == 11'd0) return {bits[63], 31'd0};
        fe   = int'(bits[62:52]) - 896;
        m53  = {1'b1, bits[51:0]};
        keep = m53[52:29];
        rem  = m53[28:0];
        inc  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
        if (fe <= 0) return {bits[63], 31'd0};
        m = {1'b0, keep} + {24'd0, inc};
        if (m[24]) fe = fe + 1;
        if (fe >= 255) return {bits[63], 8'hFF, 23'd0};
        return {bits[63], 8'(fe), (m[24] ? 23'd0 : m[22:0])};
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a[30:23] == 0 && b[30:23] == 0) return {a[31] & b[31], 31'd0};
        if (a[30:23] == 0) return b;
        if (b[30:23] == 0) return a;
        return real_to_fp(fp_to_real(a) + fp_to_real(b));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Drive one operand pair on the falling edge, compare one edge later.
    task automatic apply(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string name, input bit verbose);
        vec_t v;
        @(negedge clk);
        A = a;
        B = b;
        v.a = a; v.b = b; v.e = e; v.name = name;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            v = sb_q.pop_front();
            if (verbose)
                $display("txn %s: %h + %h -> %h (expect %h)", v.name, v.a, v.b, Out, v.e);
            check(v.name, Out, v.e);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          ex;

        vecs.push_back('{32'h41360001, 32'h40B2041B, 32'h41878107, "carry_sticky"});
        vecs.push_back('{32'h426FEB85, 32'h40D00000, 32'h4284F5C2, "tie_even_keep"});
        vecs.push_back('{32'h447A2000, 32'h447569DB, 32'h44F7C4EE, "eq_exp_tie_up"});
        vecs.push_back('{32'h44097F2B, 32'h40B20419, 32'h440AE333, "add_grs"});
        vecs.push_back('{32'h44097F2B, 32'hC0B20419, 32'h44081B23, "sub_grs111"});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 32'h00000000, "exact_cancel"});
        vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf"});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow"});
        vecs.push_back('{32'h7FA00001, 32'h3F800000, 32'h7FC00000, "nan_in"});
        vecs.push_back('{32'hFF800000, 32'h40A00000, 32'hFF800000, "ninf_finite"});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h3F800000, "subnormal_ftz"});
        vecs.push_back('{32'h80000000, 32'h00000000, 32'h00000000, "neg0_pos0"});
        vecs.push_back('{32'h80000000, 32'h80000000, 32'h80000000, "neg0_neg0"});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h40000000, "one_plus_one"});
        vecs.push_back('{32'h3F800000, 32'h33800000, 32'h3F800000, "tie_stay_even"});
        vecs.push_back('{32'h3F800001, 32'h33800000, 32'h3F800002, "tie_odd_up"});
        vecs.push_back('{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, "sub_renorm"});
        vecs.push_back('{32'h00800001, 32'h80800000, 32'h00000000, "underflow_ftz"});
        vecs.push_back('{32'h3F800000, 32'h0DA00000, 32'h3F800000, "far_sticky"});

        rst = 1'b1;
        A   = 32'd0;
        B   = 32'd0;
        #3;
        check("reset_state", Out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].name, 1'b1);

        // Asynchronous reset mid-run, then the first sum after release.
        apply(32'h40400000, 32'h40800000, 32'h40E00000, "pre_reset", 1'b1);
        @(negedge clk);
        A = 32'h3F800000;
        B = 32'h3F800000;
        #2;
        rst = 1'b1;
        #1;
        $display("txn rst_async: Out=%h", Out);
        check("rst_async", Out, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold", Out, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        apply(32'h40000000, 32'h40000000, 32'h40800000, "post_reset", 1'b1);

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) begin
                ex = int'(ra[30:23]) + $urandom_range(6) - 3;
                if (ex < 1) ex = 1;
                if (ex > 254) ex = 254;
                rb[30:23] = 8'(ex);
            end
            if (i % 17 == 0) rb = ra ^ 32'h8000_0001;
            apply(ra, rb, model_add(ra, rb), "random", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
